// File: rtl/mlp_result_reader.sv
// mlp_result_reader
//   Streams the output-layer neurons of an MLP out of data RAM once the core
//   has written all of them. Writes into the output region are snooped and
//   counted; when H of them have been seen the block reads each neuron through
//   RAM port B and presents it on a valid/ready stream.
//
//   Optional feature: define MLP_ARGMAX_EN to track the signed maximum of the
//   streamed values and its index (class_idx/class_val). Without it both
//   outputs are tied to 0.
//
// Ports
//   clk          single clock, all state changes on posedge
//   reset        asynchronous active-low reset
//   start        one-cycle pulse, arms a read-out (accepted in IDLE/DONE)
//   H            number of output neurons, sampled on an accepted start
//   snoop_wr     data-RAM write strobe from the core
//   snoop_add    data-RAM write address from the core
//   mem_rd_add   registered read address to data-RAM port B
//   mem_rd_data  port B read data, valid one clock after the address edge
//   out_data     signed neuron value
//   out_idx      neuron index of out_data
//   out_valid    stream valid
//   out_ready    stream ready
//   out_last     marks index H-1
//   busy         armed or reading
//   done         level, set after the last transfer until the next start
//   class_idx    argmax index (0 when feature disabled)
//   class_val    argmax value (0 when feature disabled)
module mlp_result_reader #(
   parameter logic [9:0] data_out_m = 10'h200,
   parameter logic [7:0] MAX_H      = 8'd255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] H,
   input  logic       snoop_wr,
   input  logic [9:0] snoop_add,
   output logic [9:0] mem_rd_add,
   input  logic [7:0] mem_rd_data,
   output logic [7:0] out_data,
   output logic [7:0] out_idx,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       done,
   output logic [7:0] class_idx,
   output logic [7:0] class_val
);

   typedef enum logic [2:0] {IDLE, WAIT, ISSUE, CAPT, SEND, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  h_r;
   logic [7:0]  wcnt;
   logic [7:0]  idx;
   logic [10:0] snoop_off;
   logic        snoop_hit;
   logic        start_ok;
   logic        wait_full;
   logic        xfer;

   // Offset of the snooped write from the region base; an address below the
   // base goes negative (bit 10 set), so only offsets 0..255 leave the top
   // three bits clear.
   assign snoop_off = {1'b0, snoop_add} - {1'b0, data_out_m};
   assign snoop_hit = snoop_wr && (snoop_off[10:8] == 3'b000);

   assign start_ok  = start && ((state == IDLE) || (state == DONE)) &&
                      ({1'b0, H} <= {1'b0, MAX_H});
   assign wait_full = (wcnt == h_r);
   assign xfer      = (state == SEND) && out_ready;

   // Status decoded straight from the state register so reset clears them
   // asynchronously together with the state.
   assign busy      = (state == WAIT) || (state == ISSUE) ||
                      (state == CAPT) || (state == SEND);
   assign done      = (state == DONE);
   assign out_valid = (state == SEND);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start_ok) state_nxt = (H == 8'd0) ? DONE : WAIT;
         WAIT:       if (wait_full) state_nxt = ISSUE;
         ISSUE:      state_nxt = CAPT;
         CAPT:       state_nxt = SEND;
         SEND:       if (out_ready) state_nxt = out_last ? DONE : ISSUE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_r        <= '0;
         wcnt       <= '0;
         idx        <= '0;
         mem_rd_add <= '0;
         out_data   <= '0;
         out_idx    <= '0;
         out_last   <= 1'b0;
      end else begin
         if (start_ok) begin
            h_r  <= H;
            wcnt <= '0;
            idx  <= '0;
         end
         case (state)
            WAIT: begin
               if (snoop_hit && !wait_full) wcnt <= wcnt + 8'd1;
               // Address is registered on entry to ISSUE so it is stable for
               // the whole ISSUE cycle and RAM data is ready by end of CAPT.
               if (wait_full) mem_rd_add <= data_out_m + {2'b00, idx};
            end
            CAPT: begin
               out_data <= mem_rd_data;
               out_idx  <= idx;
               out_last <= (idx == h_r - 8'd1);
            end
            SEND: begin
               if (out_ready && !out_last) begin
                  idx        <= idx + 8'd1;
                  mem_rd_add <= data_out_m + {2'b00, idx} + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MLP_ARGMAX_EN
   logic [7:0] best_idx;
   logic [7:0] best_val;

   // Strict greater-than keeps the lower index on ties; the first transfer
   // always seeds the maximum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         best_idx <= '0;
         best_val <= '0;
      end else if (start_ok) begin
         best_idx <= '0;
         best_val <= '0;
      end else if (xfer) begin
         if ((out_idx == 8'd0) || ($signed(out_data) > $signed(best_val))) begin
            best_idx <= out_idx;
            best_val <= out_data;
         end
      end
   end

   assign class_idx = best_idx;
   assign class_val = best_val;
`else
   logic unused_xfer;
   assign unused_xfer = xfer;
   assign class_idx   = '0;
   assign class_val   = '0;
`endif

endmodule

// File: tb/tb_mlp_result_reader.sv
// Scoreboard bench for mlp_result_reader: expected stream entries are queued
// when a job is armed and popped by a monitor on each accepted transfer.
module tb_mlp_result_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] H;
   logic       snoop_wr;
   logic [9:0] snoop_add;
   logic [9:0] mem_rd_add;
   logic [7:0] mem_rd_data;
   logic [7:0] out_data;
   logic [7:0] out_idx;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       done;
   logic [7:0] class_idx;
   logic [7:0] class_val;

   mlp_result_reader dut (
      .clk(clk), .reset(reset), .start(start), .H(H),
      .snoop_wr(snoop_wr), .snoop_add(snoop_add),
      .mem_rd_add(mem_rd_add), .mem_rd_data(mem_rd_data),
      .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done),
      .class_idx(class_idx), .class_val(class_val)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [0:1023];
   always @(posedge clk) mem_rd_data <= ram[mem_rd_add];

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] idx;
      logic       last;
      logic [9:0] addr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   xfer_cyc[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_xfer", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("xfer_data", out_data, mon_e.data);
            check("xfer_idx", out_idx, mon_e.idx);
            check("xfer_last", out_last, mon_e.last);
            check("xfer_addr", mem_rd_add, mon_e.addr);
            xfer_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] h);
      start = 1'b1;
      H     = h;
      tick();
      start = 1'b0;
   endtask

   task automatic snoop(input logic [9:0] a);
      snoop_wr  = 1'b1;
      snoop_add = a;
      tick();
      snoop_wr  = 1'b0;
   endtask

   task automatic push_exp(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.data = ram[10'h200 + i];
         e.idx  = 8'(i);
         e.last = (i == n - 1);
         e.addr = 10'(10'h200 + i);
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      check("wait_done", done, 1'b1);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!out_valid && k < budget) begin
         tick();
         k++;
      end
      check("wait_valid", out_valid, 1'b1);
   endtask

   task automatic check_class(input int n);
      logic [7:0] ci;
      logic [7:0] cv;
      ci = 8'd0;
      cv = 8'd0;
`ifdef MLP_ARGMAX_EN
      for (int i = 0; i < n; i++) begin
         if (i == 0 || $signed(ram[10'h200 + i]) > $signed(cv)) begin
            ci = 8'(i);
            cv = ram[10'h200 + i];
         end
      end
`endif
      check("class_idx", class_idx, ci);
      check("class_val", class_val, cv);
   endtask

   task automatic check_all_zero();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'd0);
      check("rst_out_idx", out_idx, 8'd0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_mem_rd_add", mem_rd_add, 10'd0);
      check("rst_class_idx", class_idx, 8'd0);
      check("rst_class_val", class_val, 8'd0);
   endtask

   initial begin
      int n0;
      logic [7:0] d_s;
      logic [7:0] i_s;
      logic       l_s;

      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      reset = 1'b0; start = 1'b0; H = 8'd0;
      snoop_wr = 1'b0; snoop_add = 10'd0; out_ready = 1'b0;
      #1;
      check_all_zero();
      tick(); tick();
      reset = 1'b1;
      tick();

      // Basic three-element read-out with ready high.
      ram[10'h200] = 8'h10; ram[10'h201] = 8'hF0; ram[10'h202] = 8'h7F;
      xfer_cyc.delete();
      push_exp(3);
      out_ready = 1'b1;
      do_start(8'd3);
      check("t1_busy_wait", busy, 1'b1);
      snoop(10'h200); snoop(10'h201); snoop(10'h202);
      wait_done(40);
      check("t1_sb_empty", sb.size(), 0);
      check("t1_busy_done", busy, 1'b0);
      check("t1_nxfer", xfer_cyc.size(), 3);
      if (xfer_cyc.size() == 3) begin
         check("t1_rate01", xfer_cyc[1] - xfer_cyc[0], 3);
         check("t1_rate12", xfer_cyc[2] - xfer_cyc[1], 3);
      end
      check_class(3);

      // Out-of-region writes ignored, start ignored while armed.
      ram[10'h200] = 8'h33; ram[10'h201] = 8'hC4;
      push_exp(2);
      do_start(8'd2);
      snoop(10'h100); snoop(10'h105); snoop(10'h1FF); snoop(10'h300);
      snoop(10'h200);
      do_start(8'd5);
      repeat (4) tick();
      check("t2_still_wait_busy", busy, 1'b1);
      check("t2_still_wait_valid", out_valid, 1'b0);
      check("t2_still_wait_done", done, 1'b0);
      snoop(10'h201);
      wait_done(40);
      check("t2_sb_empty", sb.size(), 0);
      check_class(2);

      // Back-pressure: outputs hold while ready is low.
      ram[10'h200] = 8'h55; ram[10'h201] = 8'h66;
      out_ready = 1'b0;
      push_exp(2);
      do_start(8'd2);
      snoop(10'h200); snoop(10'h201);
      wait_valid(20);
      d_s = out_data; i_s = out_idx; l_s = out_last;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3_hold_valid", out_valid, 1'b1);
         check("t3_hold_data", out_data, d_s);
         check("t3_hold_idx", out_idx, i_s);
         check("t3_hold_last", out_last, l_s);
      end
      out_ready = 1'b1;
      tick();
      check("t3_first_ready_xfer", out_valid, 1'b0);
      wait_done(40);
      check("t3_sb_empty", sb.size(), 0);

      // H == 0 from IDLE: done immediately, never busy.
      reset = 1'b0; tick(); reset = 1'b1; tick();
      check("t4_done_before", done, 1'b0);
      do_start(8'd0);
      check("t4_done", done, 1'b1);
      for (int k = 0; k < 4; k++) begin
         check("t4_busy", busy, 1'b0);
         check("t4_valid", out_valid, 1'b0);
         tick();
      end
      check_class(0);

      // Asynchronous reset in SEND of idx 1, then a fresh H=1 job.
      ram[10'h200] = 8'h11; ram[10'h201] = 8'h22;
      out_ready = 1'b0;
      push_exp(2);
      do_start(8'd2);
      snoop(10'h200); snoop(10'h201);
      wait_valid(20);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_valid(20);
      check("t5_idx1", out_idx, 8'd1);
      sb.delete();
      #2 reset = 1'b0;
      #1;
      check_all_zero();
      tick();
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (5) tick();
      check("t5_no_valid_after_reset", out_valid, 1'b0);
      ram[10'h200] = 8'h5A;
      n0 = xfer_cyc.size();
      push_exp(1);
      do_start(8'd1);
      snoop(10'h200);
      wait_done(40);
      check("t5_one_xfer", xfer_cyc.size() - n0, 1);
      check("t5_sb_empty", sb.size(), 0);
      check_class(1);

      // Equal values: lower index wins.
      ram[10'h200] = 8'h20; ram[10'h201] = 8'h20;
      push_exp(2);
      do_start(8'd2);
      snoop(10'h200); snoop(10'h201);
      wait_done(40);
      check("t6_sb_empty", sb.size(), 0);
      check_class(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
